// File: rtl/mfp_ahb_ram_slave_ws.sv
// AHB-Lite RAM slave with a fixed number of wait states per OKAY data phase,
// a two-cycle ERROR response for illegal transfers and configurable byte-lane order.
module mfp_ahb_ram_slave_ws #(
  parameter int ADDR_WIDTH  = 6,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HBURST,
  input  logic        HMASTLOCK,
  input  logic [3:0]  HPROT,
  input  logic        HSEL,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic        HREADYIN,
  input  logic        SI_Endian,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  localparam int          DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [2:0]  WS    = 3'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t                  r_state;
  logic [2:0]              r_cnt;
  logic                    r_dp_act;
  logic                    r_dp_write;
  logic [ADDR_WIDTH-1:0]   r_dp_idx;
  logic [3:0]              r_dp_mask;
  logic                    r_hready;
  logic                    r_hresp;
  logic [31:0]             r_hrdata;
  logic [31:0]             r_mem [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0]   w_haddr_idx;
  logic                    w_accept;
  logic                    w_legal;
  logic                    w_ready_phase;
  logic                    w_commit;
  logic [31:0]             w_rd_fwd;
  logic [31:0]             w_rd_dp;
  logic                    w_unused;

  // Byte-lane enables; big-endian mirrors the lane index within the word.
  function automatic logic [3:0] f_lane_mask(input logic [2:0] size, input logic [1:0] a,
                                             input logic big);
    logic [1:0] lane;
    logic [3:0] m;
    lane = big ? (2'd3 - a) : a;
    case (size)
      3'd0:    m = 4'b0001 << lane;
      3'd1:    m = (a[1] ^ big) ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] m);
    logic [31:0] m32;
    m32 = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (old_w & ~m32) | (new_w & m32);
  endfunction

  assign w_haddr_idx   = HADDR[ADDR_WIDTH+1:2];
  assign w_accept      = HSEL & HTRANS[1] & HREADYIN;
  assign w_legal       = (HSIZE == 3'd0) ||
                         ((HSIZE == 3'd1) && (HADDR[0] == 1'b0)) ||
                         ((HSIZE == 3'd2) && (HADDR[1:0] == 2'b00));
  assign w_ready_phase = (r_state == S_IDLE) || (r_state == S_ERR2) ||
                         ((r_state == S_WAIT) && (r_cnt == 3'd0));
  assign w_commit      = r_dp_act & r_dp_write & (r_cnt == 3'd0);
  // A read accepted on the same edge as a write commit must see the merged word.
  assign w_rd_fwd      = (w_commit && (r_dp_idx == w_haddr_idx)) ?
                         f_merge(r_mem[w_haddr_idx], HWDATA, r_dp_mask) : r_mem[w_haddr_idx];
  assign w_rd_dp       = r_mem[r_dp_idx];
  assign w_unused      = ^{HBURST, HMASTLOCK, HPROT, HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign HRDATA = r_hrdata;
  assign HREADY = r_hready;
  assign HRESP  = r_hresp;

  // Transfer FSM: captures the address phase and sequences wait/error data phases.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_dp_act   <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_idx   <= '0;
      r_dp_mask  <= 4'd0;
      r_hready   <= 1'b1;
      r_hresp    <= 1'b0;
      r_hrdata   <= 32'd0;
    end else if (r_state == S_ERR1) begin
      r_state  <= S_ERR2;
      r_hready <= 1'b1;
      r_hresp  <= 1'b1;
      r_hrdata <= 32'd0;
    end else if (!w_ready_phase) begin
      r_cnt <= r_cnt - 3'd1;
      if (r_cnt == 3'd1) begin
        r_hready <= 1'b1;
        r_hrdata <= r_dp_write ? 32'd0 : w_rd_dp;
      end else begin
        r_hready <= 1'b0;
        r_hrdata <= 32'd0;
      end
    end else if (w_accept && w_legal) begin
      r_dp_act   <= 1'b1;
      r_dp_write <= HWRITE;
      r_dp_idx   <= w_haddr_idx;
      r_dp_mask  <= f_lane_mask(HSIZE, HADDR[1:0], SI_Endian);
      r_hresp    <= 1'b0;
      if (WAIT_STATES == 0) begin
        r_state  <= S_IDLE;
        r_cnt    <= 3'd0;
        r_hready <= 1'b1;
        r_hrdata <= HWRITE ? 32'd0 : w_rd_fwd;
      end else begin
        r_state  <= S_WAIT;
        r_cnt    <= WS;
        r_hready <= 1'b0;
        r_hrdata <= 32'd0;
      end
    end else if (w_accept) begin
      r_state  <= S_ERR1;
      r_cnt    <= 3'd0;
      r_dp_act <= 1'b0;
      r_hready <= 1'b0;
      r_hresp  <= 1'b1;
      r_hrdata <= 32'd0;
    end else begin
      r_state  <= S_IDLE;
      r_cnt    <= 3'd0;
      r_dp_act <= 1'b0;
      r_hready <= 1'b1;
      r_hresp  <= 1'b0;
      r_hrdata <= 32'd0;
    end
  end

  // Storage array: commits write lanes at the end of the completing data phase.
  always_ff @(posedge HCLK) begin
    if (w_commit) begin
      r_mem[r_dp_idx] <= f_merge(r_mem[r_dp_idx], HWDATA, r_dp_mask);
    end
  end

endmodule
